// File: rtl/trap_sequencer_if.sv
// Bundle between the machine-mode trap sequencer and its CSR file / core neighbours.
// The master modport is the sequencer; the slave modport is the CSR file and core side.
interface trap_sequencer_if;
    logic        mstatus_MIE;
    logic        mstatus_MPIE;
    logic        mie_MSIE;
    logic        mie_MTIE;
    logic        mie_MEIE;
    logic        mip_MSIP;
    logic        mip_MTIP;
    logic        mip_MEIP;
    logic [1:0]  mtvec_MODE;
    logic [29:0] mtvec_BASE;
    logic [31:0] mepc_REG;
    logic        boundary_valid;
    logic [31:0] next_pc;
    logic        exc_valid;
    logic [3:0]  exc_code;
    logic [31:0] exc_pc;
    logic        mret_valid;
    logic        csr_port_owned;
    logic        csr_WE_L;
    logic [11:0] csr_address;
    logic [31:0] csr_write_data;
    logic        stall_core;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    // Events are level requests sampled only while the sequencer is idle; a request that
    // is not accepted is simply dropped and must be re-presented (no queueing, no ready).
    modport master (
        input  mstatus_MIE, mstatus_MPIE, mie_MSIE, mie_MTIE, mie_MEIE,
        input  mip_MSIP, mip_MTIP, mip_MEIP, mtvec_MODE, mtvec_BASE, mepc_REG,
        input  boundary_valid, next_pc, exc_valid, exc_code, exc_pc, mret_valid,
        output csr_port_owned, csr_WE_L, csr_address, csr_write_data,
        output stall_core, redirect_valid, redirect_pc
    );

    modport slave (
        output mstatus_MIE, mstatus_MPIE, mie_MSIE, mie_MTIE, mie_MEIE,
        output mip_MSIP, mip_MTIP, mip_MEIP, mtvec_MODE, mtvec_BASE, mepc_REG,
        output boundary_valid, next_pc, exc_valid, exc_code, exc_pc, mret_valid,
        input  csr_port_owned, csr_WE_L, csr_address, csr_write_data,
        input  stall_core, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/trap_sequencer.sv
// Machine-mode trap/mret sequencer: writes mepc/mcause/mstatus through the CSR port, then redirects fetch.
// Optional feature macro: VECTORED_MODE_EN (vectored interrupt targets when mtvec_MODE==1).
module trap_sequencer #(
    parameter int unsigned IRQ_QUALIFY_CYCLES = 1
) (
    input  logic             clock,
    input  logic             reset_L,
    trap_sequencer_if.master bus,
    output logic [2:0]       dbg_state_o
);
    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_WR_MEPC     = 3'd1,
        S_WR_MCAUSE   = 3'd2,
        S_WR_MSTATUS  = 3'd3,
        S_MRET_STATUS = 3'd4,
        S_REDIRECT    = 3'd5
    } state_e;

    localparam logic [3:0] QUAL = 4'(IRQ_QUALIFY_CYCLES);

    state_e      state_q;
    logic [3:0]  qual_cnt_q, qual_cnt_d;
    logic [31:0] cause_q, status_q, target_q;
    logic        we_l_q, owned_q, stall_q, redirect_valid_q;
    logic [11:0] addr_q;
    logic [31:0] data_q, redirect_pc_q;

    logic        irq_mei, irq_msi, irq_mti, irq_ok, qualified, idle;
    logic        irq_take_ok, take_exc, take_irq, take_mret, accept_trap;
    logic [3:0]  irq_code;
    logic [31:0] trap_cause, trap_epc, trap_target, trap_status, mret_status, base_addr;

    assign irq_mei   = bus.mie_MEIE & bus.mip_MEIP;
    assign irq_msi   = bus.mie_MSIE & bus.mip_MSIP;
    assign irq_mti   = bus.mie_MTIE & bus.mip_MTIP;
    assign irq_ok    = bus.mstatus_MIE & (irq_mei | irq_msi | irq_mti);
    assign qualified = (qual_cnt_q == QUAL);
    assign idle      = (state_q == S_IDLE);

    // irq_ok is also required at accept so the cause is taken from a still-pending line.
    assign irq_take_ok = qualified & irq_ok & bus.boundary_valid;
    assign take_exc    = idle & bus.exc_valid;
    assign take_irq    = idle & ~bus.exc_valid & irq_take_ok;
    assign take_mret   = idle & ~bus.exc_valid & ~irq_take_ok & bus.mret_valid;
    assign accept_trap = take_exc | take_irq;

    assign irq_code   = irq_mei ? 4'd11 : (irq_msi ? 4'd3 : 4'd7);
    assign trap_cause = take_exc ? {28'h0, bus.exc_code} : {1'b1, 27'h0, irq_code};
    assign trap_epc   = take_exc ? bus.exc_pc : bus.next_pc;
    assign base_addr  = {bus.mtvec_BASE, 2'b00};

`ifdef VECTORED_MODE_EN
    assign trap_target = (take_irq && bus.mtvec_MODE == 2'd1)
                       ? base_addr + {26'h0, irq_code, 2'b00}
                       : base_addr;
`else
    logic unused_mode;
    assign unused_mode = ^bus.mtvec_MODE;
    assign trap_target = base_addr;
`endif

    // mstatus image layout: MPP[12:11], MPIE[7], MIE[3].
    assign trap_status = {19'b0, 2'b11, 3'b0, bus.mstatus_MIE, 3'b0, 1'b0, 3'b0};
    assign mret_status = {19'b0, 2'b11, 3'b0, 1'b1, 3'b0, bus.mstatus_MPIE, 3'b0};

    always_comb begin
        qual_cnt_d = 4'd0;
        if (accept_trap)
            qual_cnt_d = 4'd0;
        else if (irq_ok)
            qual_cnt_d = qualified ? qual_cnt_q : qual_cnt_q + 4'd1;
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state_q          <= S_IDLE;
            qual_cnt_q       <= 4'd0;
            cause_q          <= 32'h0;
            status_q         <= 32'h0;
            target_q         <= 32'h0;
            we_l_q           <= 1'b1;
            owned_q          <= 1'b0;
            stall_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'h0;
            addr_q           <= 12'h0;
            data_q           <= 32'h0;
        end else begin
            qual_cnt_q <= qual_cnt_d;
            case (state_q)
                S_IDLE: begin
                    if (accept_trap) begin
                        state_q  <= S_WR_MEPC;
                        we_l_q   <= 1'b0;
                        owned_q  <= 1'b1;
                        stall_q  <= 1'b1;
                        addr_q   <= 12'h341;
                        data_q   <= trap_epc;
                        cause_q  <= trap_cause;
                        status_q <= trap_status;
                        target_q <= trap_target;
                    end else if (take_mret) begin
                        state_q  <= S_MRET_STATUS;
                        we_l_q   <= 1'b0;
                        owned_q  <= 1'b1;
                        stall_q  <= 1'b1;
                        addr_q   <= 12'h300;
                        data_q   <= mret_status;
                        target_q <= bus.mepc_REG;
                    end
                end
                S_WR_MEPC: begin
                    state_q <= S_WR_MCAUSE;
                    addr_q  <= 12'h342;
                    data_q  <= cause_q;
                end
                S_WR_MCAUSE: begin
                    state_q <= S_WR_MSTATUS;
                    addr_q  <= 12'h300;
                    data_q  <= status_q;
                end
                S_WR_MSTATUS, S_MRET_STATUS: begin
                    state_q          <= S_REDIRECT;
                    we_l_q           <= 1'b1;
                    owned_q          <= 1'b0;
                    redirect_valid_q <= 1'b1;
                    redirect_pc_q    <= target_q;
                end
                S_REDIRECT: begin
                    state_q          <= S_IDLE;
                    redirect_valid_q <= 1'b0;
                    stall_q          <= 1'b0;
                end
                default: begin
                    state_q          <= S_IDLE;
                    we_l_q           <= 1'b1;
                    owned_q          <= 1'b0;
                    stall_q          <= 1'b0;
                    redirect_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // The accept cycle itself must hold the core, before any state register has moved.
    assign bus.stall_core     = stall_q | (reset_L & (accept_trap | take_mret));
    assign bus.csr_WE_L       = we_l_q;
    assign bus.csr_port_owned = owned_q;
    assign bus.csr_address    = addr_q;
    assign bus.csr_write_data = data_q;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign dbg_state_o        = state_q;
endmodule
